// File: rtl/idex_pkg.sv
// ---------------------------------------------------------------------------
// idex_pkg
//   Shared definitions for the ID/EX pipeline slice of the five-stage MIPS
//   datapath.
//
//   Contents:
//     - field width constants (WB_W, M_W, EX_W, WORD_W, REG_W, IDEX_W)
//     - MSB/LSB bit positions of every field inside the 147-bit ID/EX bus
//     - idex_t, a packed struct whose layout matches the bus bit for bit
//     - packIdex(), which assembles an idex_t from individual fields
//
//   Bus layout, MSB first:
//     wb[146:145] m[144:142] ex[141:138] add4[137:106] readData1[105:74]
//     readData2[73:42] signExt[41:10] rt[9:5] rd[4:0]
// ---------------------------------------------------------------------------
package idex_pkg;

  localparam int WB_W   = 2;
  localparam int M_W    = 3;
  localparam int EX_W   = 4;
  localparam int WORD_W = 32;
  localparam int REG_W  = 5;
  localparam int IDEX_W = WB_W + M_W + EX_W + 4 * WORD_W + 2 * REG_W;  // 147

  // Field positions, listed from the LSB end upwards so that each field
  // starts right above the previous one.
  localparam int RD_LSB         = 0;
  localparam int RD_MSB         = RD_LSB + REG_W - 1;                  // 4
  localparam int RT_LSB         = RD_MSB + 1;                          // 5
  localparam int RT_MSB         = RT_LSB + REG_W - 1;                  // 9
  localparam int SIGN_EXT_LSB   = RT_MSB + 1;                          // 10
  localparam int SIGN_EXT_MSB   = SIGN_EXT_LSB + WORD_W - 1;           // 41
  localparam int READ_DATA2_LSB = SIGN_EXT_MSB + 1;                    // 42
  localparam int READ_DATA2_MSB = READ_DATA2_LSB + WORD_W - 1;         // 73
  localparam int READ_DATA1_LSB = READ_DATA2_MSB + 1;                  // 74
  localparam int READ_DATA1_MSB = READ_DATA1_LSB + WORD_W - 1;         // 105
  localparam int ADD4_LSB       = READ_DATA1_MSB + 1;                  // 106
  localparam int ADD4_MSB       = ADD4_LSB + WORD_W - 1;               // 137
  localparam int EX_LSB         = ADD4_MSB + 1;                        // 138
  localparam int EX_MSB         = EX_LSB + EX_W - 1;                   // 141
  localparam int M_LSB          = EX_MSB + 1;                          // 142
  localparam int M_MSB          = M_LSB + M_W - 1;                     // 144
  localparam int WB_LSB         = M_MSB + 1;                           // 145
  localparam int WB_MSB         = WB_LSB + WB_W - 1;                   // 146

  // Control group (wb, m, ex) occupies the top bits of the bus; a pipeline
  // bubble clears exactly this range.
  localparam int CTRL_LSB = EX_LSB;
  localparam int CTRL_MSB = WB_MSB;
  localparam int CTRL_W   = CTRL_MSB - CTRL_LSB + 1;                   // 9

  typedef struct packed {
    logic [WB_W-1:0]   wb;         // {memToReg, regWrite}
    logic [M_W-1:0]    m;          // {branch, memRead, memWrite}
    logic [EX_W-1:0]   ex;         // {aluSrc, regDst, aluOp[1:0]}
    logic [WORD_W-1:0] add4;
    logic [WORD_W-1:0] readData1;
    logic [WORD_W-1:0] readData2;
    logic [WORD_W-1:0] signExt;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
  } idex_t;

  function automatic idex_t packIdex(
    input logic [WB_W-1:0]   wb,
    input logic [M_W-1:0]    m,
    input logic [EX_W-1:0]   ex,
    input logic [WORD_W-1:0] add4,
    input logic [WORD_W-1:0] readData1,
    input logic [WORD_W-1:0] readData2,
    input logic [WORD_W-1:0] signExt,
    input logic [REG_W-1:0]  rt,
    input logic [REG_W-1:0]  rd
  );
    idex_t bus;
    bus.wb        = wb;
    bus.m         = m;
    bus.ex        = ex;
    bus.add4      = add4;
    bus.readData1 = readData1;
    bus.readData2 = readData2;
    bus.signExt   = signExt;
    bus.rt        = rt;
    bus.rd        = rd;
    return bus;
  endfunction

endpackage

// File: rtl/adder32.sv
// ---------------------------------------------------------------------------
// adder32
//   Plain 32-bit adder. The carry-out is dropped, so the sum wraps modulo
//   2^32. Used both for the fetch-side PC+4 and for the branch target.
//
//   Ports:
//     a    in  32  first operand
//     b    in  32  second operand
//     sum  out 32  (a + b) mod 2^32, combinational
// ---------------------------------------------------------------------------
module adder32
  import idex_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic [WORD_W-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/idex_branch_stage.sv
// ---------------------------------------------------------------------------
// idex_branch_stage
//   Decode-to-execute slice of the five-stage MIPS pipeline: the ID/EX
//   pipeline register (one 147-bit bus, see idex_pkg for the layout), the
//   fetch-side PC+4 adder and the execute-side branch-target adder.
//
//   Optional feature (compile-time macro IDEX_FLUSH_EN):
//     when defined, a 'flush' input is added. flush=1 at a rising edge loads
//     a bubble: wb/m/ex become zero while all data fields still load from
//     the inputs. flush wins over en=0. Without the macro there is no flush
//     port and the control fields load like data fields.
//
//   Ports:
//     clk           in   1    pipeline clock, rising edge
//     rst           in   1    asynchronous, active-low reset of the register
//     en            in   1    1 = capture inputs on the edge, 0 = hold
//     flush         in   1    bubble insert (IDEX_FLUSH_EN builds only)
//     pc_in         in   32   current PC, fetch side
//     pc_plus4      out  32   pc_in + 4, combinational
//     wb_in         in   2    {memToReg, regWrite}
//     m_in          in   3    {branch, memRead, memWrite}
//     ex_in         in   4    {aluSrc, regDst, aluOp[1:0]}
//     add4_in       in   32   PC+4 carried through IF/ID
//     read_data1    in   32   register file port 1 data
//     read_data2    in   32   register file port 2 data
//     sign_ext      in   32   sign-extended immediate
//     rt            in   5    instruction bits [20:16]
//     rd            in   5    instruction bits [15:11]
//     idex_out      out  147  registered ID/EX bus
//     branch_target out  32   registered add4 + (registered sign_ext << 2)
// ---------------------------------------------------------------------------
module idex_branch_stage
  import idex_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
`ifdef IDEX_FLUSH_EN
  input  logic              flush,
`endif
  input  logic [WORD_W-1:0] pc_in,
  output logic [WORD_W-1:0] pc_plus4,
  input  logic [WB_W-1:0]   wb_in,
  input  logic [M_W-1:0]    m_in,
  input  logic [EX_W-1:0]   ex_in,
  input  logic [WORD_W-1:0] add4_in,
  input  logic [WORD_W-1:0] read_data1,
  input  logic [WORD_W-1:0] read_data2,
  input  logic [WORD_W-1:0] sign_ext,
  input  logic [REG_W-1:0]  rt,
  input  logic [REG_W-1:0]  rd,
  output logic [IDEX_W-1:0] idex_out,
  output logic [WORD_W-1:0] branch_target
);

  localparam logic [WORD_W-1:0] PC_STEP = WORD_W'(4);

  idex_t             captureBus;   // what a normal capture would load
  logic [IDEX_W-1:0] idexReg;
  logic [IDEX_W-1:0] idexNext;
  logic [WORD_W-1:0] branchOffset;

  // ---------------------------------------------------------------------
  // Fetch-side PC+4; independent of the register and of reset.
  // ---------------------------------------------------------------------
  adder32 pcAdder (
    .a   (pc_in),
    .b   (PC_STEP),
    .sum (pc_plus4)
  );

  // ---------------------------------------------------------------------
  // Next-state of the ID/EX register
  // ---------------------------------------------------------------------
  assign captureBus = packIdex(wb_in, m_in, ex_in, add4_in, read_data1,
                               read_data2, sign_ext, rt, rd);

  always_comb begin
    idexNext = idexReg;
    if (en) begin
      idexNext = captureBus;
    end
`ifdef IDEX_FLUSH_EN
    // A bubble still carries the data fields so that forwarding/hazard
    // logic downstream sees consistent operands; only the controls die.
    if (flush) begin
      idexNext                   = captureBus;
      idexNext[CTRL_MSB:CTRL_LSB] = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idexReg <= '0;
    end else begin
      idexReg <= idexNext;
    end
  end

  assign idex_out = idexReg;

  // ---------------------------------------------------------------------
  // Execute-side branch target from the registered fields only. The word
  // offset is formed by dropping the top two immediate bits and appending
  // two zeros; two's-complement wrap makes negative offsets subtract.
  // ---------------------------------------------------------------------
  assign branchOffset = {idexReg[SIGN_EXT_MSB-2:SIGN_EXT_LSB], 2'b00};

  adder32 branchAdder (
    .a   (idexReg[ADD4_MSB:ADD4_LSB]),
    .b   (branchOffset),
    .sum (branch_target)
  );

endmodule

// File: tb/tb_idex_branch_stage.sv
// ---------------------------------------------------------------------------
// tb_idex_branch_stage
//   Self-checking bench for idex_branch_stage. A behavioural model holds the
//   expected ID/EX contents as separate field variables; branch targets are
//   computed arithmetically (add4 + 4*offset). Define IDEX_FLUSH_EN to also
//   exercise the bubble-insert input.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_idex_branch_stage;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en  = 1'b0;
  logic         flush = 1'b0;
  logic [31:0]  pc_in = '0;
  logic [31:0]  pc_plus4;
  logic [1:0]   wb_in = '0;
  logic [2:0]   m_in = '0;
  logic [3:0]   ex_in = '0;
  logic [31:0]  add4_in = '0;
  logic [31:0]  read_data1 = '0;
  logic [31:0]  read_data2 = '0;
  logic [31:0]  sign_ext = '0;
  logic [4:0]   rt = '0;
  logic [4:0]   rd = '0;
  logic [146:0] idex_out;
  logic [31:0]  branch_target;

  int checks   = 0;
  int failures = 0;

  // Model of the registered stage, one variable per field.
  logic [1:0]  eWb;
  logic [2:0]  eM;
  logic [3:0]  eEx;
  logic [31:0] eAdd4, eRd1, eRd2, eSext;
  logic [4:0]  eRt, eRd;

  idex_branch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
`ifdef IDEX_FLUSH_EN
    .flush         (flush),
`endif
    .pc_in         (pc_in),
    .pc_plus4      (pc_plus4),
    .wb_in         (wb_in),
    .m_in          (m_in),
    .ex_in         (ex_in),
    .add4_in       (add4_in),
    .read_data1    (read_data1),
    .read_data2    (read_data2),
    .sign_ext      (sign_ext),
    .rt            (rt),
    .rd            (rd),
    .idex_out      (idex_out),
    .branch_target (branch_target)
  );

  always #5 clk = ~clk;

  function automatic logic flushActive();
`ifdef IDEX_FLUSH_EN
    return flush;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [146:0] expBus();
    return {eWb, eM, eEx, eAdd4, eRd1, eRd2, eSext, eRt, eRd};
  endfunction

  function automatic logic [31:0] expBranch();
    return eAdd4 + eSext * 32'd4;
  endfunction

  task automatic modelClear();
    eWb = '0; eM = '0; eEx = '0; eAdd4 = '0; eRd1 = '0; eRd2 = '0;
    eSext = '0; eRt = '0; eRd = '0;
  endtask

  task automatic randInputs();
    wb_in      = 2'($urandom);
    m_in       = 3'($urandom);
    ex_in      = 4'($urandom);
    add4_in    = $urandom & 32'hFFFF_FFFC;
    read_data1 = $urandom;
    read_data2 = $urandom;
    // Mostly genuine sign-extended 16-bit immediates, sometimes raw words.
    if ($urandom_range(0, 3) != 0) sign_ext = 32'(signed'(16'($urandom)));
    else                           sign_ext = $urandom;
    rt         = 5'($urandom);
    rd         = 5'($urandom);
    pc_in      = $urandom;
  endtask

  // One rising edge; model follows the edge, outputs sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    if (rst && (en || flushActive())) begin
      if (flushActive()) begin
        eWb = '0; eM = '0; eEx = '0;
      end else begin
        eWb = wb_in; eM = m_in; eEx = ex_in;
      end
      eAdd4 = add4_in; eRd1 = read_data1; eRd2 = read_data2;
      eSext = sign_ext; eRt = rt; eRd = rd;
    end
    #1;
  endtask

  task automatic test_reset();
    modelClear();
    rst = 1'b0; en = 1'b1;
    randInputs();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (idex_out !== 147'd0) begin
      failures++;
      $display("FAIL reset_idex: got %h want 0", idex_out);
    end
    checks++;
    if (branch_target !== 32'd0) begin
      failures++;
      $display("FAIL reset_branch: got %h want 0", branch_target);
    end
    pc_in = 32'h0000_1234;
    #1;
    checks++;
    if (pc_plus4 !== 32'h0000_1238) begin
      failures++;
      $display("FAIL reset_pc_plus4: got %h want 00001238", pc_plus4);
    end
    @(negedge clk);
    rst = 1'b1; en = 1'b0;
    $display("reset: idex_out=%h branch_target=%h", idex_out, branch_target);
  endtask

  task automatic test_pc_adder();
    logic [31:0] pcs [2] = '{32'h0040_0000, 32'hFFFF_FFFC};
    logic [31:0] want [2] = '{32'h0040_0004, 32'h0000_0000};
    for (int i = 0; i < 2; i++) begin
      pc_in = pcs[i];
      #1;
      checks++;
      if (pc_plus4 !== want[i]) begin
        failures++;
        $display("FAIL pc_adder_fixed: pc_in=%h got %h want %h", pc_in, pc_plus4, want[i]);
      end else $display("pc_adder: pc_in=%h pc_plus4=%h", pc_in, pc_plus4);
    end
    for (int i = 0; i < 8; i++) begin
      pc_in = $urandom;
      #1;
      checks++;
      if (pc_plus4 !== pc_in + 32'd4) begin
        failures++;
        $display("FAIL pc_adder_rand: pc_in=%h got %h want %h", pc_in, pc_plus4, pc_in + 32'd4);
      end else $display("pc_adder: pc_in=%h pc_plus4=%h", pc_in, pc_plus4);
    end
  endtask

  task automatic test_field_packing();
    @(negedge clk);
    en = 1'b1; flush = 1'b0;
    wb_in = 2'b10; m_in = 3'b101; ex_in = 4'b1100;
    add4_in = 32'h1111_1111; read_data1 = 32'h2222_2222;
    read_data2 = 32'h3333_3333; sign_ext = 32'h4444_4444;
    rt = 5'h1A; rd = 5'h05;
    step();
    checks++; if (idex_out[146:145] !== 2'b10) begin failures++; $display("FAIL pack_wb: got %b want 10", idex_out[146:145]); end
    checks++; if (idex_out[144:142] !== 3'b101) begin failures++; $display("FAIL pack_m: got %b want 101", idex_out[144:142]); end
    checks++; if (idex_out[141:138] !== 4'b1100) begin failures++; $display("FAIL pack_ex: got %b want 1100", idex_out[141:138]); end
    checks++; if (idex_out[137:106] !== 32'h1111_1111) begin failures++; $display("FAIL pack_add4: got %h want 11111111", idex_out[137:106]); end
    checks++; if (idex_out[105:74] !== 32'h2222_2222) begin failures++; $display("FAIL pack_rd1: got %h want 22222222", idex_out[105:74]); end
    checks++; if (idex_out[73:42] !== 32'h3333_3333) begin failures++; $display("FAIL pack_rd2: got %h want 33333333", idex_out[73:42]); end
    checks++; if (idex_out[41:10] !== 32'h4444_4444) begin failures++; $display("FAIL pack_sext: got %h want 44444444", idex_out[41:10]); end
    checks++; if (idex_out[9:5] !== 5'h1A) begin failures++; $display("FAIL pack_rt: got %h want 1a", idex_out[9:5]); end
    checks++; if (idex_out[4:0] !== 5'h05) begin failures++; $display("FAIL pack_rd: got %h want 05", idex_out[4:0]); end
    // 0x11111111 + (0x44444444 << 2 mod 2^32 = 0x11111110)
    checks++; if (branch_target !== 32'h2222_2221) begin failures++; $display("FAIL pack_branch: got %h want 22222221", branch_target); end
    $display("field_packing: idex_out=%h branch_target=%h", idex_out, branch_target);
  endtask

  task automatic test_branch();
    logic [31:0] a4 [2]   = '{32'h0040_0008, 32'h0040_0010};
    logic [31:0] se [2]   = '{32'h0000_0003, 32'hFFFF_FFFE};
    logic [31:0] want [2] = '{32'h0040_0014, 32'h0040_0008};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      en = 1'b1;
      add4_in = a4[i]; sign_ext = se[i];
      #1;
      // Not captured yet: target must still reflect the previous contents.
      checks++;
      if (branch_target !== expBranch()) begin
        failures++;
        $display("FAIL branch_pre_capture: got %h want %h", branch_target, expBranch());
      end
      step();
      checks++;
      if (branch_target !== want[i]) begin
        failures++;
        $display("FAIL branch_fixed: add4=%h sext=%h got %h want %h", a4[i], se[i], branch_target, want[i]);
      end else $display("branch: add4=%h sext=%h target=%h", a4[i], se[i], branch_target);
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    en = 1'b1;
    randInputs();
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      en = 1'b0;
      randInputs();
      step();
      checks++;
      if (idex_out !== expBus() || branch_target !== expBranch()) begin
        failures++;
        $display("FAIL hold: got %h/%h want %h/%h", idex_out, branch_target, expBus(), expBranch());
      end else $display("hold: cycle %0d idex_out=%h", i, idex_out);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      en = 1'($urandom);
      randInputs();
      step();
      checks++;
      if (idex_out !== expBus() || branch_target !== expBranch()) begin
        failures++;
        $display("FAIL random: en=%b got %h/%h want %h/%h", en, idex_out, branch_target, expBus(), expBranch());
      end else $display("random: en=%b idex_out=%h target=%h", en, idex_out, branch_target);
    end
  endtask

`ifdef IDEX_FLUSH_EN
  task automatic test_flush();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      en = (i % 2 == 0) ? 1'b0 : 1'b1;
      flush = 1'b1;
      randInputs();
      wb_in = 2'b11; m_in = 3'b111; ex_in = 4'b1111;
      step();
      checks++;
      if (idex_out[146:138] !== 9'd0 || idex_out !== expBus()) begin
        failures++;
        $display("FAIL flush: en=%b got %h want %h", en, idex_out, expBus());
      end else $display("flush: en=%b idex_out=%h", en, idex_out);
    end
    @(negedge clk);
    flush = 1'b0;
  endtask
`endif

  task automatic test_async_reset();
    @(negedge clk);
    en = 1'b1;
    randInputs();
    wb_in = 2'b01;  // guarantee a nonzero bus
    step();
    #1;
    rst = 1'b0;     // mid-cycle, no clock edge before the check
    modelClear();
    #1;
    checks++;
    if (idex_out !== 147'd0 || branch_target !== 32'd0) begin
      failures++;
      $display("FAIL async_reset: got %h/%h want 0/0", idex_out, branch_target);
    end
    // Reset overrides en while held.
    step();
    checks++;
    if (idex_out !== 147'd0) begin
      failures++;
      $display("FAIL reset_over_en: got %h want 0", idex_out);
    end
    // Release between edges; the next edge with en=1 captures.
    #2;
    rst = 1'b1;
    randInputs();
    step();
    checks++;
    if (idex_out !== expBus() || branch_target !== expBranch()) begin
      failures++;
      $display("FAIL first_capture: got %h/%h want %h/%h", idex_out, branch_target, expBus(), expBranch());
    end
    $display("async_reset: idex_out=%h target=%h", idex_out, branch_target);
  endtask

  initial begin
    test_reset();
    test_pc_adder();
    test_field_packing();
    test_branch();
    test_hold();
    test_random();
`ifdef IDEX_FLUSH_EN
    test_flush();
    test_random();
`endif
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
